// File: rtl/multi_track_loader_pkg.sv
// Shared types and helpers for the multi-drive track loader.
package mtl_pkg;

  localparam int unsigned SECTOR_BYTES = 512;

  typedef enum logic [1:0] {IDLE, WRITE, LOAD} fsm_t;

  function automatic logic [31:0] lba_of(input logic [31:0] track,
                                         input logic [31:0] sec,
                                         input int unsigned spt);
    return 32'(spt) * track + sec;
  endfunction

endpackage

// File: rtl/multi_track_loader_track_buffer.sv
// Whole-track buffer: true dual-port byte RAM with registered, enable-gated reads.
module track_buffer
  import mtl_pkg::*;
#(
  parameter int unsigned SECS_PER_TRACK = 13,
  parameter int unsigned AW             = 13
) (
  input  logic          clk,
  input  logic          en_a,
  input  logic          we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [7:0]    din_a,
  output logic [7:0]    dout_a,
  input  logic          en_b,
  input  logic          we_b,
  input  logic [AW-1:0] addr_b,
  input  logic [7:0]    din_b,
  output logic [7:0]    dout_b
);

  logic [7:0] mem [SECS_PER_TRACK*SECTOR_BYTES];

  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= din_a;
    if (we_b) mem[addr_b] <= din_b;
    if (en_a) dout_a <= mem[addr_a];
    if (en_b) dout_b <= mem[addr_b];
  end

endmodule

// File: rtl/multi_track_loader.sv
// Round-robin track loader serving DRIVES floppy track buffers over the sd_* block interface.
module multi_track_loader
  import mtl_pkg::*;
#(
  parameter int unsigned DRIVES         = 2,
  parameter int unsigned SECS_PER_TRACK = 13,
  parameter int unsigned TRACK_W        = 6,
  parameter int unsigned FA_W           = 13
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DRIVES*TRACK_W-1:0]   track,
  input  logic [DRIVES-1:0]           active,
  input  logic [DRIVES-1:0]           img_mounted,
  input  logic [63:0]                 img_size,
  output logic [DRIVES*32-1:0]        lba_fdd,
  output logic [DRIVES-1:0]           sd_rd,
  output logic [DRIVES-1:0]           sd_wr,
  input  logic [DRIVES-1:0]           sd_ack,
  input  logic [8:0]                  sd_buff_addr,
  input  logic                        sd_buff_wr,
  input  logic [7:0]                  sd_buff_dout,
  output logic [DRIVES*8-1:0]         sd_buff_din,
  input  logic [FA_W-1:0]             fd_track_addr,
  input  logic                        fd_write_disk,
  input  logic [7:0]                  fd_data_do,
  output logic [7:0]                  fd_data_in,
  output logic                        cpu_wait
);

  localparam int unsigned SEC_W = (SECS_PER_TRACK > 1) ? $clog2(SECS_PER_TRACK) : 1;
  localparam int unsigned SEL_W = (DRIVES > 1) ? $clog2(DRIVES) : 1;
  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SECS_PER_TRACK - 1);

  fsm_t                            state_q, state_d;
  logic [SEL_W-1:0]                sel_q, sel_d, rr_q, rr_d;
  logic [SEC_W-1:0]                sec_q, sec_d;
  logic                            req_q, req_d;
  logic [DRIVES-1:0]               mounted_q, mounted_d, valid_q, valid_d, dirty_q, dirty_d;
  logic [DRIVES-1:0]               ack_q;
  logic [DRIVES-1:0][TRACK_W-1:0]  cur_q, cur_d, trk;
  logic [DRIVES-1:0][31:0]         lba_q, lba_d;
  logic                            act_hit_q;
  logic [SEL_W-1:0]                act_idx_q;

  logic [DRIVES-1:0] need;
  logic              any_act, busy, ack_rise, ack_fall, fd_we, found;
  logic [SEL_W-1:0]  act_idx;
  logic [7:0]        q_b [DRIVES];
  int unsigned       idx;

  assign trk      = track;
  assign busy     = (state_q != IDLE);
  assign ack_rise = sd_ack[sel_q] & ~ack_q[sel_q];
  assign ack_fall = ~sd_ack[sel_q] & ack_q[sel_q];

  always_comb begin
    need     = '0;
    any_act  = 1'b0;
    act_idx  = '0;
    cpu_wait = 1'b0;
    sd_rd    = '0;
    sd_wr    = '0;
    for (int unsigned d = 0; d < DRIVES; d++) begin
      need[d] = mounted_q[d] & (~valid_q[d] | (cur_q[d] != trk[d]));
      if (active[d] && !any_act) begin
        any_act = 1'b1;
        act_idx = SEL_W'(d);
      end
      cpu_wait = cpu_wait | (active[d] & (need[d] | (busy & (sel_q == SEL_W'(d)))));
      sd_rd[d] = (state_q == LOAD)  & req_q & (sel_q == SEL_W'(d));
      sd_wr[d] = (state_q == WRITE) & req_q & (sel_q == SEL_W'(d));
    end
  end

  // Controller writes are locked out while the engine owns this drive's buffer,
  // and a mount in the same cycle discards the write.
  assign fd_we = fd_write_disk & any_act & valid_q[act_idx] & ~(busy & (sel_q == act_idx))
               & ~img_mounted[act_idx];

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    rr_d      = rr_q;
    sec_d     = sec_q;
    req_d     = req_q;
    mounted_d = mounted_q;
    valid_d   = valid_q;
    dirty_d   = dirty_q;
    cur_d     = cur_q;
    lba_d     = lba_q;
    found     = 1'b0;
    idx       = 0;

    unique case (state_q)
      IDLE: begin
        for (int unsigned k = 0; k < DRIVES; k++) begin
          idx = 32'(rr_q) + k;
          if (idx >= DRIVES) idx = idx - DRIVES;
          if (!found && need[idx]) begin
            found = 1'b1;
            sel_d = SEL_W'(idx);
          end
        end
        if (found) begin
          sec_d = '0;
          req_d = 1'b1;
          if (dirty_q[sel_d]) begin
            state_d = WRITE;
          end else begin
            state_d       = LOAD;
            cur_d[sel_d]  = trk[sel_d];
          end
        end
      end
      WRITE: begin
        if (ack_rise && sec_q == SEC_LAST) req_d = 1'b0;
        if (ack_fall) begin
          if (!req_q) begin
            dirty_d[sel_q] = 1'b0;
            sec_d          = '0;
            req_d          = 1'b1;
            state_d        = LOAD;
            cur_d[sel_q]   = trk[sel_q];
          end else begin
            sec_d = sec_q + 1'b1;
          end
        end
      end
      LOAD: begin
        if (ack_rise && sec_q == SEC_LAST) req_d = 1'b0;
        if (ack_fall) begin
          if (!req_q) begin
            valid_d[sel_q] = 1'b1;
            rr_d           = (sel_q == SEL_W'(DRIVES - 1)) ? '0 : sel_q + 1'b1;
            sec_d          = '0;
            state_d        = IDLE;
          end else begin
            sec_d = sec_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != IDLE)
      lba_d[sel_d] = lba_of(32'(cur_d[sel_d]), 32'(sec_d), SECS_PER_TRACK);

    if (fd_we) dirty_d[act_idx] = 1'b1;

    for (int unsigned d = 0; d < DRIVES; d++) begin
      if (img_mounted[d]) begin
        mounted_d[d] = |img_size;
        valid_d[d]   = 1'b0;
        dirty_d[d]   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      rr_q      <= '0;
      sec_q     <= '0;
      req_q     <= 1'b0;
      mounted_q <= '0;
      valid_q   <= '0;
      dirty_q   <= '0;
      ack_q     <= '0;
      cur_q     <= '0;
      lba_q     <= '0;
      act_hit_q <= 1'b0;
      act_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      rr_q      <= rr_d;
      sec_q     <= sec_d;
      req_q     <= req_d;
      mounted_q <= mounted_d;
      valid_q   <= valid_d;
      dirty_q   <= dirty_d;
      ack_q     <= sd_ack;
      cur_q     <= cur_d;
      lba_q     <= lba_d;
      act_hit_q <= any_act;
      act_idx_q <= act_idx;
    end
  end

  assign lba_fdd    = lba_q;
  assign fd_data_in = act_hit_q ? q_b[act_idx_q] : 8'hFF;

  for (genvar g = 0; g < DRIVES; g++) begin : g_buf
    logic own_a;
    assign own_a = busy & (sel_q == SEL_W'(g));

    track_buffer #(
      .SECS_PER_TRACK (SECS_PER_TRACK),
      .AW             (FA_W)
    ) u_buf (
      .clk    (clk),
      .en_a   (own_a),
      .we_a   (own_a & sd_buff_wr & sd_ack[g]),
      .addr_a (FA_W'({sec_q, sd_buff_addr})),
      .din_a  (sd_buff_dout),
      .dout_a (sd_buff_din[g*8 +: 8]),
      .en_b   (any_act & (act_idx == SEL_W'(g))),
      .we_b   (fd_we & (act_idx == SEL_W'(g))),
      .addr_b (fd_track_addr),
      .din_b  (fd_data_do),
      .dout_b (q_b[g])
    );
  end

endmodule

// File: tb/tb_multi_track_loader.sv
// Directed bench: an HPS model serves sector requests with a known byte pattern.
module tb_multi_track_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] track = '0;
  logic [1:0]  active = '0;
  logic [1:0]  img_mounted = '0;
  logic [63:0] img_size = '0;
  logic [63:0] lba_fdd;
  logic [1:0]  sd_rd, sd_wr;
  logic [1:0]  sd_ack = '0;
  logic [8:0]  sd_buff_addr = '0;
  logic        sd_buff_wr = 1'b0;
  logic [7:0]  sd_buff_dout = '0;
  logic [15:0] sd_buff_din;
  logic [12:0] fd_track_addr = '0;
  logic        fd_write_disk = 1'b0;
  logic [7:0]  fd_data_do = '0;
  logic [7:0]  fd_data_in;
  logic        cpu_wait;

  int checks = 0;
  int errors = 0;
  logic [7:0] wr_b4, wr_b5;

  multi_track_loader #(
    .DRIVES(2), .SECS_PER_TRACK(13), .TRACK_W(6), .FA_W(13)
  ) dut (
    .clk(clk), .reset(reset), .track(track), .active(active),
    .img_mounted(img_mounted), .img_size(img_size), .lba_fdd(lba_fdd),
    .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr),
    .sd_buff_wr(sd_buff_wr), .sd_buff_dout(sd_buff_dout), .sd_buff_din(sd_buff_din),
    .fd_track_addr(fd_track_addr), .fd_write_disk(fd_write_disk),
    .fd_data_do(fd_data_do), .fd_data_in(fd_data_in), .cpu_wait(cpu_wait)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pat(input int lba, input int i);
    return 8'(lba * 3 + i);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Serve nsec sectors on drive drv; each must be a write (is_wr) or read at lba base+s.
  task automatic serve(input int drv, input bit is_wr, input int base, input int nsec);
    for (int s = 0; s < nsec; s++) begin
      int n = 0;
      while (!(sd_rd[drv] | sd_wr[drv]) && n < 50) begin
        tick();
        n++;
      end
      chk("req_type", {62'd0, sd_wr[drv], sd_rd[drv]}, is_wr ? 64'd2 : 64'd1);
      chk("lba", 64'(lba_fdd[drv*32 +: 32]), 64'(base + s));
      sd_ack[drv] = 1'b1;
      if (is_wr) begin
        for (int i = 0; i < 512; i++) begin
          sd_buff_addr = 9'(i);
          tick();
          if (s == 0 && i == 4) wr_b4 = sd_buff_din[drv*8 +: 8];
          if (s == 0 && i == 5) wr_b5 = sd_buff_din[drv*8 +: 8];
        end
      end else begin
        sd_buff_wr = 1'b1;
        for (int i = 0; i < 512; i++) begin
          sd_buff_addr = 9'(i);
          sd_buff_dout = pat(base + s, i);
          tick();
        end
        sd_buff_wr = 1'b0;
      end
      sd_ack[drv] = 1'b0;
      tick();
    end
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_sd_rd", 64'(sd_rd), 64'd0);
    chk("rst_sd_wr", 64'(sd_wr), 64'd0);
    chk("rst_lba", lba_fdd, 64'd0);
    chk("rst_cpu_wait", 64'(cpu_wait), 64'd0);
    chk("rst_fd_data_in", 64'(fd_data_in), 64'hFF);
    reset = 1'b0;
    tick();

    // Mount drive 0 and load track 0
    img_size = 64'd143360; track = 12'd0; active = 2'b01; img_mounted = 2'b01;
    tick();
    img_mounted = 2'b00;
    chk("mount_wait", 64'(cpu_wait), 64'd1);
    serve(0, 1'b0, 0, 13);
    chk("load_done_wait", 64'(cpu_wait), 64'd0);
    fd_track_addr = 13'h0200;
    tick();
    chk("buf_0x200", 64'(fd_data_in), 64'(pat(1, 0)));

    // Dirty write-back then load of track 3
    fd_track_addr = 13'h0005; fd_data_do = 8'hA5; fd_write_disk = 1'b1;
    tick();
    fd_write_disk = 1'b0;
    tick();
    chk("fd_readback", 64'(fd_data_in), 64'hA5);
    track = 12'd3;
    serve(0, 1'b1, 0, 13);
    chk("wb_byte5", 64'(wr_b5), 64'hA5);
    chk("wb_byte4", 64'(wr_b4), 64'(pat(0, 4)));
    serve(0, 1'b0, 39, 13);
    chk("t3_done_wait", 64'(cpu_wait), 64'd0);

    // Two drives needing tracks 2 and 7
    reset = 1'b1; tick(); reset = 1'b0;
    track = {6'd7, 6'd2}; active = 2'b01; img_mounted = 2'b11;
    tick();
    img_mounted = 2'b00;
    chk("two_wait", 64'(cpu_wait), 64'd1);
    serve(0, 1'b0, 26, 12);
    chk("two_wait_mid", 64'(cpu_wait), 64'd1);
    serve(0, 1'b0, 38, 1);
    chk("two_d0_done", 64'(cpu_wait), 64'd0);
    serve(1, 1'b0, 91, 13);
    chk("lba0_hold", 64'(lba_fdd[31:0]), 64'd38);
    chk("two_idle_rd", 64'(sd_rd), 64'd0);

    // Reset in the middle of sector 5
    reset = 1'b1; tick(); reset = 1'b0;
    track = 12'd0; active = 2'b01; img_mounted = 2'b01;
    tick();
    img_mounted = 2'b00;
    serve(0, 1'b0, 0, 5);
    for (int n = 0; n < 50 && !sd_rd[0]; n++) tick();
    chk("sec5_lba", 64'(lba_fdd[31:0]), 64'd5);
    sd_ack[0] = 1'b1; sd_buff_wr = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sd_buff_addr = 9'(i);
      tick();
    end
    reset = 1'b1;
    tick();
    chk("midrst_sd_rd", 64'(sd_rd), 64'd0);
    chk("midrst_wait", 64'(cpu_wait), 64'd0);
    sd_ack[0] = 1'b0; sd_buff_wr = 1'b0; reset = 1'b0;
    tick(); tick();
    chk("midrst_idle", 64'(sd_rd), 64'd0);
    img_mounted = 2'b01;
    tick();
    img_mounted = 2'b00;
    chk("remount_wait", 64'(cpu_wait), 64'd1);
    serve(0, 1'b0, 0, 13);
    chk("reload_done", 64'(cpu_wait), 64'd0);

    // Zero-size mount: no requests, FF when nothing is active
    img_size = 64'd0; img_mounted = 2'b01;
    tick();
    img_mounted = 2'b00; active = 2'b00;
    tick(); tick(); tick();
    chk("empty_rd", 64'(sd_rd), 64'd0);
    chk("empty_wr", 64'(sd_wr), 64'd0);
    chk("empty_wait", 64'(cpu_wait), 64'd0);
    chk("empty_ff", 64'(fd_data_in), 64'hFF);
    chk("empty_lba_hold", 64'(lba_fdd[31:0]), 64'd12);
    active = 2'b01;
    tick();
    chk("empty_active_wait", 64'(cpu_wait), 64'd0);

    // Write in the same cycle as a mount: no write-back afterwards
    img_size = 64'd143360; img_mounted = 2'b01;
    tick();
    img_mounted = 2'b00;
    serve(0, 1'b0, 0, 13);
    fd_track_addr = 13'h0005; fd_data_do = 8'h5A; fd_write_disk = 1'b1;
    img_mounted = 2'b01; track = 12'd1;
    tick();
    fd_write_disk = 1'b0; img_mounted = 2'b00;
    serve(0, 1'b0, 13, 13);
    chk("race_done", 64'(cpu_wait), 64'd0);
    tick();
    chk("race_byte5", 64'(fd_data_in), 64'(pat(13, 5)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
